cpu_boot_loader: RTL and testbench

- Hardware boot loader that sits directly upstream of the cpu external memory-load ports.
- Accepts a byte stream over a valid/ready handshake and decodes framed load commands.
- Writes decoded words into instruction memory (32-bit, addr_ext/wen_ext/wdata_ext) or data memory (64-bit, addr_ext_2/wen_ext_2/wdata_ext_2).
- On a GO command it asserts the cpu enable and stays in run mode until reset, replacing the bench-driven load sequence.

---
 rtl/cpu_boot_loader.sv | 127 ++++++++++++
 tb/tb_cpu_boot_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader: byte-stream frame decoder that loads the cpu imem/dmem and then releases the cpu.
// Ports:
//   clk, arst_n                  clock and asynchronous active-low reset
//   s_valid, s_data, s_ready     byte stream handshake (transfer on s_valid & s_ready)
//   addr_ext, wen_ext, ren_ext, wdata_ext           imem write port (32-bit words)
//   addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2   dmem write port (64-bit words)
//   enable                       cpu run enable, sticky once 'G' is accepted
//   busy                         frame in progress (not IDLE, not RUN)
//   err                          sticky error: bad header, oversize count or watchdog abort
module cpu_boot_loader #(
    parameter int IMEM_DEPTH = 128,
    parameter int DMEM_DEPTH = 128,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        enable,
    output logic        busy,
    output logic        err
);
    typedef enum logic [2:0] {S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_WRITE, S_RUN} state_t;

    localparam logic [31:0] LP_IMEM    = 32'(IMEM_DEPTH);
    localparam logic [31:0] LP_DMEM    = 32'(DMEM_DEPTH);
    localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic        r_tgt;
    logic [15:0] r_cnt, r_word_idx;
    logic [2:0]  r_byte_idx;
    logic [63:0] r_word;
    logic        r_err;
    logic [31:0] r_wdog;
    logic        w_fire, w_framing, w_last, w_timeout, w_err_set, w_wen;
    logic [31:0] w_cnt_new, w_depth;

    assign s_ready   = r_state inside {S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA};
    assign w_fire    = s_valid & s_ready;
    assign w_framing = r_state inside {S_CNT_LO, S_CNT_HI, S_DATA};
    assign w_last    = r_byte_idx == (r_tgt ? 3'd7 : 3'd3);
    // Full count as it will be once the high byte now on the bus is taken.
    assign w_cnt_new = {16'd0, s_data, r_cnt[7:0]};
    assign w_depth   = r_tgt ? LP_DMEM : LP_IMEM;
    // Abort on the stalled cycle that would bring the idle count up to TIMEOUT.
    assign w_timeout = (TIMEOUT != 0) && w_framing && !w_fire && (r_wdog == LP_TO_LAST);

    assign w_wen       = r_state == S_WRITE;
    assign wen_ext     = w_wen & ~r_tgt;
    assign wen_ext_2   = w_wen & r_tgt;
    assign ren_ext     = 1'b0;
    assign ren_ext_2   = 1'b0;
    assign addr_ext    = wen_ext ? {46'd0, r_word_idx, 2'd0} : '0;
    assign wdata_ext   = wen_ext ? r_word[31:0] : '0;
    assign addr_ext_2  = wen_ext_2 ? {45'd0, r_word_idx, 3'd0} : '0;
    assign wdata_ext_2 = wen_ext_2 ? r_word : '0;
    assign enable      = r_state == S_RUN;
    assign busy        = !(r_state inside {S_IDLE, S_RUN});
    assign err         = r_err;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: if (w_fire) begin
                if (s_data == 8'h49 || s_data == 8'h44) w_state_nxt = S_CNT_LO;
                else if (s_data == 8'h47)               w_state_nxt = S_RUN;
                else                                    w_err_set   = 1'b1;
            end
            S_CNT_LO: if (w_fire) w_state_nxt = S_CNT_HI;
            S_CNT_HI: if (w_fire) begin
                w_state_nxt = (w_cnt_new == 32'd0 || w_cnt_new > w_depth) ? S_IDLE : S_DATA;
                w_err_set   = w_cnt_new > w_depth;
            end
            S_DATA:  if (w_fire && w_last) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = (r_word_idx + 16'd1 != r_cnt) ? S_DATA : S_IDLE;
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_err_set   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_tgt      <= 1'b0;
            r_cnt      <= '0;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_err      <= 1'b0;
            r_wdog     <= '0;
        end else begin
            if (w_err_set) r_err <= 1'b1;
            r_wdog <= (w_framing && !w_fire && !w_timeout) ? r_wdog + 32'd1 : 32'd0;
            if (r_state == S_IDLE && w_fire) r_tgt <= s_data == 8'h44;
            if (r_state == S_CNT_LO && w_fire) r_cnt[7:0] <= s_data;
            if (r_state == S_CNT_HI && w_fire) begin
                r_cnt[15:8] <= s_data;
                r_word_idx  <= '0;
                r_byte_idx  <= '0;
            end
            if (r_state == S_DATA && w_fire) begin
                r_word[{r_byte_idx, 3'd0} +: 8] <= s_data;
                r_byte_idx <= w_last ? 3'd0 : r_byte_idx + 3'd1;
            end
            if (r_state == S_WRITE) r_word_idx <= r_word_idx + 16'd1;
        end
    end
endmodule

// File: tb/tb_cpu_boot_loader.sv
// tb_cpu_boot_loader: randomized frame-level checking of cpu_boot_loader against an expected-write queue.
module tb_cpu_boot_loader;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, busy, err;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] wdata_ext;

    cpu_boot_loader #(.IMEM_DEPTH(DEPTH), .DMEM_DEPTH(DEPTH), .TIMEOUT(16)) dut (
        .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
        .enable(enable), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {logic d; logic [63:0] a; logic [63:0] w;} wr_t;
    wr_t         exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          max_gap = 0;
    logic        want_err = 1'b0;
    logic [63:0] fw[DEPTH];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, want, $time);
        end
    endtask

    // Every write the DUT makes must be the next one the bench expects.
    always @(negedge clk) begin
        wr_t e;
        check("one_wen", {63'd0, wen_ext & wen_ext_2}, 64'd0);
        check("ren_zero", {62'd0, ren_ext, ren_ext_2}, 64'd0);
        if (!wen_ext) check("imem_bus_idle", addr_ext | {32'd0, wdata_ext}, 64'd0);
        if (!wen_ext_2) check("dmem_bus_idle", addr_ext_2 | wdata_ext_2, 64'd0);
        if (wen_ext || wen_ext_2) begin
            if (exp_q.size() == 0) check("unexpected_wr", 64'd1, 64'd0);
            else begin
                e = exp_q.pop_front();
                check("wr_tgt", {63'd0, wen_ext_2}, {63'd0, e.d});
                check("wr_addr", wen_ext_2 ? addr_ext_2 : addr_ext, e.a);
                check("wr_data", wen_ext_2 ? wdata_ext_2 : {32'd0, wdata_ext}, e.w);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        repeat ($urandom_range(max_gap, 0)) tick();
        s_valid = 1'b1;
        s_data  = b;
        k = 0;
        while (!s_ready && k < 50) begin
            tick();
            k++;
        end
        if (!s_ready) check("ready_wait", 64'd0, 64'd1);
        else tick();
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic d, input int n);
        logic [15:0] c;
        wr_t e;
        c = 16'(n);
        send_byte(d ? 8'h44 : 8'h49);
        send_byte(c[7:0]);
        send_byte(c[15:8]);
        if (n > DEPTH) want_err = 1'b1;
        else for (int i = 0; i < n; i++) begin
            e.d = d;
            e.a = d ? 64'(i) * 8 : 64'(i) * 4;
            e.w = d ? fw[i] : {32'd0, fw[i][31:0]};
            exp_q.push_back(e);
            for (int b = 0; b < (d ? 8 : 4); b++) send_byte(e.w[8*b +: 8]);
            check("wr_strobe", {63'd0, d ? wen_ext_2 : wen_ext}, 64'd1);
            check("wr_ready", {63'd0, s_ready}, 64'd0);
        end
        tick();
        check("frame_busy", {63'd0, busy}, 64'd0);
        check("frame_pending", 64'(exp_q.size()), 64'd0);
        check("frame_err", {63'd0, err}, {63'd0, want_err});
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) fw[i] = {$urandom, $urandom};
    endtask

    initial begin
        logic [7:0] hb;
        repeat (2) tick();
        check("rst_ready", {63'd0, s_ready}, 64'd1);
        check("rst_outs", {60'd0, enable, busy, err, wen_ext | wen_ext_2}, 64'd0);
        arst_n = 1'b1;
        tick();

        fw[0] = 64'h00700413;
        fw[1] = 64'h00900493;
        send_frame(1'b0, 2);
        fw[0] = 64'h000000123456789A;
        send_frame(1'b1, 1);

        send_byte(8'h44);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (15) tick();
        check("wdog_before_busy", {63'd0, busy}, 64'd1);
        check("wdog_before_err", {63'd0, err}, 64'd0);
        tick();
        want_err = 1'b1;
        check("wdog_busy", {63'd0, busy}, 64'd0);
        check("wdog_err", {63'd0, err}, 64'd1);
        fill(1);
        send_frame(1'b1, 1);

        send_byte(8'h55);
        check("bad_hdr_err", {63'd0, err}, 64'd1);
        check("bad_hdr_busy", {63'd0, busy}, 64'd0);
        send_frame(1'b0, DEPTH + 1);
        fw[0] = 64'h12345678;
        send_frame(1'b0, 1);

        fill(DEPTH);
        send_frame(1'b0, DEPTH);

        max_gap = 3;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(9, 0))
                0: begin
                    hb = 8'($urandom);
                    while (hb == 8'h49 || hb == 8'h44 || hb == 8'h47) hb = 8'($urandom);
                    send_byte(hb);
                    want_err = 1'b1;
                    check("rnd_bad_err", {63'd0, err}, 64'd1);
                end
                1: send_frame(1'($urandom), 0);
                2: send_frame(1'($urandom), DEPTH + 1 + int'($urandom_range(5, 0)));
                default: begin
                    fill(8);
                    send_frame(1'($urandom), int'($urandom_range(6, 1)));
                end
            endcase
        end

        max_gap = 0;
        send_byte(8'h49);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        arst_n = 1'b0;
        #1;
        want_err = 1'b0;
        check("arst_ready", {63'd0, s_ready}, 64'd1);
        check("arst_outs", {60'd0, enable, busy, err, wen_ext | wen_ext_2}, 64'd0);
        repeat (2) tick();
        arst_n = 1'b1;
        tick();

        send_byte(8'h47);
        check("go_enable", {63'd0, enable}, 64'd1);
        check("go_ready", {63'd0, s_ready}, 64'd0);
        check("go_busy", {63'd0, busy}, 64'd0);
        s_valid = 1'b1;
        s_data  = 8'h49;
        repeat (8) begin
            tick();
            check("run_ready", {63'd0, s_ready}, 64'd0);
            check("run_enable", {63'd0, enable}, 64'd1);
        end
        s_valid = 1'b0;
        check("end_pending", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
